// File: rtl/cond_flag_unit.sv
// Execute-stage conditional unit: banked {N,Z,C,V} flags, branch condition
// evaluation and write gating. Optional counters: define COND_PERF_CNT_EN.
module cond_flag_unit #(
  parameter int NUM_BANKS = 4,
  parameter int OPCODE_W = 3,
  parameter logic [OPCODE_W-1:0] BRANCH_OPCODE = 3'b110,
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic [2:0]          S,
  input  logic [BANK_W-1:0]   BankSel,
  input  logic [3:0]          ALUFlags,
  input  logic [1:0]          FlagWrite,
  input  logic                Stall,
  input  logic                PCSrcIn,
  input  logic                RegWriteIn,
  input  logic                MemWriteIn,
`ifdef COND_PERF_CNT_EN
  input  logic                CntClr,
  output logic [15:0]         TakenCnt,
  output logic [15:0]         SquashCnt,
`endif
  output logic                CondEx,
  output logic                PCSrc,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic [3:0]          Flags
);

  logic [3:0]        bank_q [NUM_BANKS];
  logic [BANK_W-1:0] idx;
  logic              is_br;
  logic              cond_ok;
  logic              n, z, v;

  // Out-of-range selects alias onto bank 0
  assign idx = (int'(BankSel) < NUM_BANKS) ? BankSel : '0;
  assign Flags = bank_q[idx];
  assign is_br = (Opcode == BRANCH_OPCODE);
  assign n = Flags[3];
  assign z = Flags[2];
  assign v = Flags[0];

  always_comb begin
    cond_ok = 1'b0;
    unique case (S)
      3'b000: cond_ok = z;
      3'b001: cond_ok = !z;
      3'b010: cond_ok = !z && (n == v);
      3'b011: cond_ok = (n != v);
      3'b100: cond_ok = (n == v);
      3'b101: cond_ok = z || (n != v);
      3'b110: cond_ok = 1'b1;
      3'b111: cond_ok = 1'b0;
    endcase
  end

  assign CondEx   = !is_br || cond_ok;
  assign PCSrc    = PCSrcIn & CondEx;
  assign RegWrite = RegWriteIn & CondEx;
  assign MemWrite = MemWriteIn & CondEx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++)
        bank_q[i] <= 4'b0000;
    end else if (!Stall && CondEx) begin
      if (FlagWrite[1])
        bank_q[idx][3:2] <= ALUFlags[3:2];
      if (FlagWrite[0])
        bank_q[idx][1:0] <= ALUFlags[1:0];
    end
  end

`ifdef COND_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TakenCnt  <= 16'd0;
      SquashCnt <= 16'd0;
    end else if (CntClr) begin
      TakenCnt  <= 16'd0;
      SquashCnt <= 16'd0;
    end else if (!Stall && is_br) begin
      if (PCSrc && TakenCnt != 16'hFFFF)
        TakenCnt <= TakenCnt + 16'd1;
      if (!CondEx && SquashCnt != 16'hFFFF)
        SquashCnt <= SquashCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit; counter checks built
// when COND_PERF_CNT_EN is defined.
module tb_cond_flag_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] Opcode;
  logic [2:0] S;
  logic [1:0] BankSel;
  logic [3:0] ALUFlags;
  logic [1:0] FlagWrite;
  logic       Stall;
  logic       PCSrcIn, RegWriteIn, MemWriteIn;
  logic       CondEx, PCSrc, RegWrite, MemWrite;
  logic [3:0] Flags;
`ifdef COND_PERF_CNT_EN
  logic        CntClr;
  logic [15:0] TakenCnt, SquashCnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cond_flag_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .Opcode(Opcode),
    .S(S),
    .BankSel(BankSel),
    .ALUFlags(ALUFlags),
    .FlagWrite(FlagWrite),
    .Stall(Stall),
    .PCSrcIn(PCSrcIn),
    .RegWriteIn(RegWriteIn),
    .MemWriteIn(MemWriteIn),
`ifdef COND_PERF_CNT_EN
    .CntClr(CntClr),
    .TakenCnt(TakenCnt),
    .SquashCnt(SquashCnt),
`endif
    .CondEx(CondEx),
    .PCSrc(PCSrc),
    .RegWrite(RegWrite),
    .MemWrite(MemWrite),
    .Flags(Flags)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] b,
                    input logic [3:0] f);
    BankSel = b;
    Opcode = 3'b000;
    ALUFlags = f;
    FlagWrite = 2'b11;
    tick();
    FlagWrite = 2'b00;
  endtask

  task automatic rd(input string tag,
                    input logic [1:0] b,
                    input logic [3:0] exp);
    BankSel = b;
    #1;
    chk(tag, 32'(Flags), 32'(exp));
  endtask

  logic [7:0] exp_s;

  initial begin
    rst_n = 1'b0;
    Opcode = 3'b110;
    S = 3'b000;
    BankSel = 2'd0;
    ALUFlags = 4'd0;
    FlagWrite = 2'b00;
    Stall = 1'b0;
    PCSrcIn = 1'b1;
    RegWriteIn = 1'b1;
    MemWriteIn = 1'b1;
`ifdef COND_PERF_CNT_EN
    CntClr = 1'b0;
`endif
    #3;
    chk("rst_flags", 32'(Flags), 0);
    chk("rst_condex", 32'(CondEx), 0);
    chk("rst_pcsrc", 32'(PCSrc), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int b = 0; b < 4; b++) begin
      rd($sformatf("init_bank%0d", b), 2'(b), 4'h0);
      chk("init_eq", 32'(CondEx), 0);
    end

    // write Z into bank1; no bypass before the edge
    BankSel = 2'd1;
    Opcode = 3'b000;
    ALUFlags = 4'b0100;
    FlagWrite = 2'b11;
    #1;
    chk("wr_condex", 32'(CondEx), 1);
    chk("wr_nobypass", 32'(Flags), 0);
    tick();
    FlagWrite = 2'b00;
    rd("bank1_z", 2'd1, 4'b0100);

    exp_s = 8'b0111_0001;
    Opcode = 3'b110;
    for (int i = 0; i < 8; i++) begin
      S = 3'(i);
      #1;
      chk($sformatf("cond_s%0d", i), 32'(CondEx), 32'(exp_s[i]));
      chk($sformatf("pc_s%0d", i), 32'(PCSrc), 32'(exp_s[i]));
    end

    // N=V=1, Z=0
    wr(2'd0, 4'b1001);
    Opcode = 3'b110;
    S = 3'b010;
    #1;
    chk("gt_condex", 32'(CondEx), 1);
    chk("gt_pcsrc", 32'(PCSrc), 1);
    S = 3'b011;
    #1;
    chk("lt_condex", 32'(CondEx), 0);
    chk("lt_gated", 32'({PCSrc, RegWrite, MemWrite}), 0);
    S = 3'b110;
    #1;
    chk("al_gated", 32'({PCSrc, RegWrite, MemWrite}), 7);

    // partial write of C,V only
    wr(2'd0, 4'b0000);
    BankSel = 2'd0;
    ALUFlags = 4'b1111;
    FlagWrite = 2'b01;
    tick();
    FlagWrite = 2'b00;
    rd("partial_cv", 2'd0, 4'b0011);

    // squashed instruction must not write
    Opcode = 3'b110;
    S = 3'b111;
    ALUFlags = 4'b1100;
    FlagWrite = 2'b11;
    tick();
    FlagWrite = 2'b00;
    rd("squash_nowr", 2'd0, 4'b0011);

    // stall blocks an executing write
    Stall = 1'b1;
    Opcode = 3'b110;
    S = 3'b011;
    ALUFlags = 4'b1000;
    FlagWrite = 2'b11;
    #1;
    chk("stall_condex", 32'(CondEx), 1);
    chk("stall_regwr", 32'(RegWrite), 1);
    tick();
    FlagWrite = 2'b00;
    Stall = 1'b0;
    rd("stall_b0", 2'd0, 4'b0011);
    rd("stall_b1", 2'd1, 4'b0100);

    wr(2'd2, 4'b1010);
    rd("ind_b2", 2'd2, 4'b1010);
    rd("ind_b0", 2'd0, 4'b0011);
    rd("ind_b1", 2'd1, 4'b0100);
    rd("ind_b3", 2'd3, 4'b0000);

    // same-cycle evaluate/write uses old flags
    BankSel = 2'd2;
    Opcode = 3'b110;
    S = 3'b011;
    ALUFlags = 4'b0100;
    FlagWrite = 2'b11;
    #1;
    chk("same_old", 32'(CondEx), 1);
    tick();
    FlagWrite = 2'b00;
    #1;
    chk("same_new_lt", 32'(CondEx), 0);
    S = 3'b000;
    #1;
    chk("same_new_eq", 32'(CondEx), 1);

    // async reset mid-cycle
    BankSel = 2'd1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_b1", 32'(Flags), 0);
    rd("mid_rst_b2", 2'd2, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wr(2'd3, 4'b1111);
    rd("post_rst_wr", 2'd3, 4'b1111);

`ifdef COND_PERF_CNT_EN
    CntClr = 1'b1;
    tick();
    CntClr = 1'b0;
    Opcode = 3'b110;
    PCSrcIn = 1'b1;
    S = 3'b110;
    repeat (3) tick();
    S = 3'b111;
    repeat (2) tick();
    Opcode = 3'b000;
    tick();
    chk("cnt_taken", 32'(TakenCnt), 3);
    chk("cnt_squash", 32'(SquashCnt), 2);

    Opcode = 3'b110;
    Stall = 1'b1;
    tick();
    Stall = 1'b0;
    chk("cnt_stall", 32'(SquashCnt), 2);

    S = 3'b110;
    repeat (65540) tick();
    chk("cnt_sat", 32'(TakenCnt), 32'hFFFF);

    CntClr = 1'b1;
    tick();
    CntClr = 1'b0;
    chk("clr_taken", 32'(TakenCnt), 0);
    chk("clr_squash", 32'(SquashCnt), 0);

    S = 3'b111;
    tick();
    chk("pre_rst_sq", 32'(SquashCnt), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_squash", 32'(SquashCnt), 0);
    chk("rst_flags3", 32'(dut.bank_q[3]), 0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
